gf32_mul_arbiter: RTL

Shares one GF(2^32) multiplier (start/done handshake, 32-bit operands) among `N_REQ` sequencing blocks of the signing pipeline, e.g. the plain-broadcast computation and the other MPC broadcast/evaluation controllers. It queues one request per requester, grants the multiplier round-robin, forwards operands, and returns the product with a per-requester done pulse. Sits between the requester controllers and the single GF32 multiplier instance.

---
 rtl/sdith_gf32_pkg.sv | 13 +
 rtl/gf32_mul_arbiter_rr_pick.sv | 33 +++
 rtl/gf32_mul_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sdith_gf32_pkg.sv
// Shared definitions for the GF(2^32) multiplier arbiter slice.
package sdith_gf32_pkg;

    localparam int GF32_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/gf32_mul_arbiter_rr_pick.sv
// Combinational round-robin picker: scans last+1, last+2, ..., last (mod N_REQ)
// and returns the first pending requester.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_pending,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_any
);

    localparam int unsigned NR = N_REQ;

    // First pending requester after the last one served, wrapping around.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cidx;
        cand    = '0;
        cidx    = '0;
        o_grant = '0;
        o_any   = 1'b0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand = (32'(i_last) + k) % NR;
            cidx = IDX_W'(cand);
            if (!o_any && i_pending[cidx]) begin
                o_grant = cidx;
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gf32_mul_arbiter.sv
// Shares one GF(2^32) multiplier among N_REQ requesters: one outstanding
// request per requester, round-robin grant, registered operands and results.
module gf32_mul_arbiter
    import sdith_gf32_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int W     = GF32_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req_start,
    input  logic [N_REQ*W-1:0] i_req_x,
    input  logic [N_REQ*W-1:0] i_req_y,
    output logic [N_REQ-1:0]   o_req_done,
    output logic [W-1:0]       o_req_out,
    output logic [N_REQ-1:0]   o_req_overflow,
    output logic               o_busy,
    output logic               o_start_mul32,
    output logic [W-1:0]       o_x_mul32,
    output logic [W-1:0]       o_y_mul32,
    input  logic [W-1:0]       i_o_mul32,
    input  logic               i_done_mul32
);

    localparam int          IDX_W = $clog2(N_REQ);
    localparam int unsigned NR    = N_REQ;
    localparam int unsigned WU    = W;

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] overflow_q, overflow_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [W-1:0]     x_q, x_d;
    logic [W-1:0]     y_q, y_d;
    logic [W-1:0]     out_q, out_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;

    logic [IDX_W-1:0] pick_grant;
    logic             pick_any;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_pending (pending_q),
        .i_last    (last_q),
        .o_grant   (pick_grant),
        .o_any     (pick_any)
    );

    // Request latching, overflow tracking and the grant/issue/wait/done sequence.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        done_d     = '0;
        grant_d    = grant_q;
        last_d     = last_q;
        x_d        = x_q;
        y_d        = y_q;
        out_d      = out_q;
        start_d    = 1'b0;
        busy_d     = busy_q;

        for (int unsigned i = 0; i < NR; i++) begin
            if (i_req_start[i]) begin
                if (pending_q[i]) begin
                    overflow_d[i] = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                end
            end
        end

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    for (int unsigned i = 0; i < NR; i++) begin
                        if (pick_grant == IDX_W'(i)) begin
                            x_d = i_req_x[i*WU +: W];
                            y_d = i_req_y[i*WU +: W];
                        end
                    end
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (i_done_mul32) begin
                    out_d              = i_o_mul32;
                    pending_d[grant_q] = 1'b0;
                    last_d             = grant_q;
                    done_d[grant_q]    = 1'b1;
                    busy_d             = 1'b0;
                    state_d            = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ARB_IDLE;
            pending_q  <= '0;
            overflow_q <= '0;
            done_q     <= '0;
            grant_q    <= '0;
            last_q     <= IDX_W'(N_REQ - 1);
            x_q        <= '0;
            y_q        <= '0;
            out_q      <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            x_q        <= x_d;
            y_q        <= y_d;
            out_q      <= out_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
        end
    end

    assign o_req_done     = done_q;
    assign o_req_out      = out_q;
    assign o_req_overflow = overflow_q;
    assign o_busy         = busy_q;
    assign o_start_mul32  = start_q;
    assign o_x_mul32      = x_q;
    assign o_y_mul32      = y_q;

endmodule
